asm_stream_arbiter: RTL and testbench

//  Round-robin scheduler that shares one serial pattern-detector FSM between NREQ requesters.

---
 rtl/asm_stream_arbiter_if.sv | 31 +++
 rtl/asm_stream_arbiter.sv | 162 ++++++++++++++++
 tb/tb_asm_stream_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/asm_stream_arbiter_if.sv
// Bundle between the requester clients, the arbiter and the shared serial detector.
interface asm_stream_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  det_clr;
    logic                  det_in;
    logic                  det_z;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [CW-1:0]         hit_cnt;

    // Arbiter side.
    modport slave (
        input  req, data, det_z,
        output gnt, busy, det_clr, det_in, done, done_id, hit_cnt
    );

    // Client / detector side.
    modport master (
        output req, data, det_z,
        input  gnt, busy, det_clr, det_in, done, done_id, hit_cnt
    );
endinterface

// File: rtl/asm_stream_arbiter.sv
// Round-robin arbiter sharing one serial pattern detector between NREQ requesters.
// The granted word is shifted MSB-first into the detector and its z pulses are counted.
module asm_stream_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    asm_stream_arbiter_if.slave bus
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned BW  = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] wreg_q, wreg_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [BW-1:0]    bi_q, bi_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             det_clr_q, det_clr_d;
    logic             det_in_q, det_in_d;
    logic             done_q, done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [CW-1:0]    hit_cnt_q, hit_cnt_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   cand;
    logic [WIDTH-1:0] wsel;
    logic [CW-1:0]    acc_next;

    // State and output registers; everything clears on reset so an aborted word leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            wreg_q    <= '0;
            id_q      <= '0;
            acc_q     <= '0;
            bi_q      <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            det_clr_q <= 1'b0;
            det_in_q  <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wreg_q    <= wreg_d;
            id_q      <= id_d;
            acc_q     <= acc_d;
            bi_q      <= bi_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            det_clr_q <= det_clr_d;
            det_in_q  <= det_in_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // Round-robin search starting at ptr, plus the winner's word and one-hot grant.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        wsel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == win) begin
                wsel = bus.data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-output logic; outputs are registered one state ahead.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wreg_d    = wreg_q;
        id_d      = id_q;
        acc_d     = acc_q;
        bi_d      = bi_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        det_clr_d = det_clr_q;
        det_in_d  = det_in_q;
        done_d    = done_q;
        done_id_d = done_id_q;
        hit_cnt_d = hit_cnt_q;
        acc_next  = acc_q + {{(CW-1){1'b0}}, bus.det_z};

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    wreg_d    = wsel;
                    id_d      = win;
                    acc_d     = '0;
                    busy_d    = 1'b1;
                    det_clr_d = 1'b1;
                    det_in_d  = 1'b0;
                    for (int k = 0; k < NREQ; k++) begin
                        gnt_d[k] = (IDW'(k) == win);
                    end
                    state_d   = StClear;
                end
            end
            StClear: begin
                det_clr_d = 1'b0;
                det_in_d  = wreg_q[WIDTH-1];
                bi_d      = BW'(WIDTH - 1);
                state_d   = StShift;
            end
            StShift: begin
                // det_z belongs to the bit currently on det_in.
                acc_d = acc_next;
                if (bi_q == '0) begin
                    det_in_d  = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    hit_cnt_d = acc_next;
                    state_d   = StDone;
                end else begin
                    bi_d     = bi_q - 1'b1;
                    det_in_d = wreg_q[bi_q - 1'b1];
                end
            end
            StDone: begin
                done_d  = 1'b0;
                gnt_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.det_clr = det_clr_q;
    assign bus.det_in  = det_in_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.hit_cnt = hit_cnt_q;
endmodule

// File: tb/tb_asm_stream_arbiter.sv
// Directed bench for asm_stream_arbiter with a small serial detector model:
// z=1 whenever det_in=1 and a 1 has already been seen since the last clear.
module tb_asm_stream_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    asm_stream_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    asm_stream_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector model, reset by rst OR det_clr as the integrator wires it.
    logic seen;
    wire  det_rst = rst | bus.det_clr;
    always @(posedge clk or posedge det_rst) begin
        if (det_rst) seen <= 1'b0;
        else if (bus.det_in) seen <= 1'b1;
    end
    assign bus.det_z = seen & bus.det_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE just before the sampling edge; walks CLEAR, 8 SHIFT cycles, DONE, IDLE.
    // mut_at >= 0 drops all requests and clears all data in that SHIFT cycle.
    task automatic service(input int exp_id, input int exp_hit, input logic [7:0] bits,
                           input int mut_at);
        logic [3:0] g;
        g = 4'b0001 << exp_id;
        tick();
        check("clr_gnt", 32'(bus.gnt), 32'(g));
        check("clr_pulse", 32'(bus.det_clr), 32'd1);
        check("clr_din", 32'(bus.det_in), 32'd0);
        check("clr_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("sh_din", 32'(bus.det_in), 32'(bits[7-i]));
            check("sh_clr", 32'(bus.det_clr), 32'd0);
            check("sh_gnt", 32'(bus.gnt), 32'(g));
            check("sh_done", 32'(bus.done), 32'd0);
            if (i == mut_at) begin
                bus.req  = '0;
                bus.data = '0;
            end
        end
        tick();
        check("dn_done", 32'(bus.done), 32'd1);
        check("dn_id", 32'(bus.done_id), 32'(exp_id));
        check("dn_hit", 32'(bus.hit_cnt), 32'(exp_hit));
        check("dn_gnt", 32'(bus.gnt), 32'(g));
        tick();
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_gnt", 32'(bus.gnt), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_hit", 32'(bus.hit_cnt), 32'(exp_hit));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.data = '0;
        #3;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_clr", 32'(bus.det_clr), 32'd0);
        check("rst_din", 32'(bus.det_in), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_id", 32'(bus.done_id), 32'd0);
        check("rst_hit", 32'(bus.hit_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_nogrant", 32'(bus.gnt), 32'd0);

        // 1: single requester 0, all ones.
        bus.data[7:0] = 8'hFF;
        bus.req       = 4'b0001;
        service(0, 7, 8'hFF, -1);
        bus.req = '0;

        // 2: requester 2, mixed pattern.
        bus.data[23:16] = 8'b1011_0110;
        bus.req         = 4'b0100;
        service(2, 4, 8'b1011_0110, -1);
        bus.req = '0;

        // 3: requester 1, all zeros.
        bus.data[15:8] = 8'h00;
        bus.req        = 4'b0010;
        service(1, 0, 8'h00, -1);
        bus.req = '0;

        // 4: everyone requesting from a fresh pointer; back-to-back words 11 cycles apart.
        do_reset();
        bus.data = {4{8'hFF}};
        bus.req  = 4'b1111;
        service(0, 7, 8'hFF, -1);
        service(1, 7, 8'hFF, -1);
        service(2, 7, 8'hFF, -1);
        service(3, 7, 8'hFF, -1);
        service(0, 7, 8'hFF, -1);
        bus.req = '0;

        // 5: requester 3 drops req and data mid-word; the latched word still completes.
        bus.data[31:24] = 8'hE1;
        bus.req         = 4'b1000;
        service(3, 3, 8'hE1, 3);
        tick();
        check("t5_noregrant", 32'(bus.gnt), 32'd0);

        // 6: reset during SHIFT aborts with no done, then requester 1 is serviced.
        bus.data[23:16] = 8'hFF;
        bus.req         = 4'b0100;
        tick();
        tick();
        tick();
        check("t6_inshift", 32'(bus.gnt), 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_gnt", 32'(bus.gnt), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_done", 32'(bus.done), 32'd0);
        check("t6_rst_din", 32'(bus.det_in), 32'd0);
        bus.req = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t6_nodone", 32'(bus.done), 32'd0);
            check("t6_idle", 32'(bus.busy), 32'd0);
        end
        bus.data[15:8] = 8'h55;
        bus.req        = 4'b0010;
        service(1, 3, 8'h55, -1);
        bus.req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
